// File: rtl/two_mode_timer_counter.sv
// MM:SS BCD stopwatch / countdown timer with run, pause, done and load control.
// Each digit's +1/-1 comes from a four-bit carry-lookahead adder, then BCD wrap correction.
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | prescaler counting, digits step once per CLK_DIV cycles
// PAUSE | digits and prescaler frozen until start
// DONE  | terminal value reached, digits held until load or rst

module two_mode_timer_counter #(
  parameter int CLK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        start,
  input  logic        stop,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        load_err
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          dir_down_q, dir_down_d;
  logic [15:0]   digits_q, digits_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;

  logic [3:0]  step_b;
  logic [3:0]  cur [4];
  logic [3:0]  sum [4];
  logic [3:0]  stepped [4];
  logic [3:0]  wrap;
  logic [3:0]  en;
  logic [15:0] step_val;
  logic [15:0] term_val;
  logic        load_legal;
  logic        start_at_term;

  assign step_b = dir_down_q ? 4'b1111 : 4'b0001;
  assign cur[0] = digits_q[3:0];
  assign cur[1] = digits_q[7:4];
  assign cur[2] = digits_q[11:8];
  assign cur[3] = digits_q[15:12];

  // Index 0 is sec_ones; sec_tens (index 1) is the only digit that tops out at 5.
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_digit
      localparam logic [3:0] DMAX = (i == 1) ? 4'd5 : 4'd9;
      FourBitCarryLookAheadAdder u_add (
        .a   (cur[i]),
        .b   (step_b),
        .cin (1'b0),
        .sum (sum[i])
      );
      assign wrap[i]    = dir_down_q ? (cur[i] == 4'd0) : (cur[i] == DMAX);
      assign stepped[i] = !en[i]  ? cur[i] :
                          wrap[i] ? (dir_down_q ? DMAX : 4'd0) : sum[i];
    end
  endgenerate

  assign en[0] = 1'b1;
  assign en[1] = wrap[0];
  assign en[2] = en[1] & wrap[1];
  assign en[3] = en[2] & wrap[2];

  assign step_val = {stepped[3], stepped[2], stepped[1], stepped[0]};
  assign term_val = dir_down_q ? 16'h0000 : 16'h9959;

  assign load_legal = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= 4'd5) &&
                      (load_val[11:8] <= 4'd9) && (load_val[15:12] <= 4'd9);
  assign start_at_term = mode ? (digits_q == 16'h0000) : (digits_q == 16'h9959);

  // A held stop blocks start in every state, but only changes state in RUN.
  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    dir_down_d = dir_down_q;
    digits_d   = digits_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_legal) begin
        digits_d = load_val;
        ps_d     = '0;
        state_d  = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start && (state_q == IDLE || state_q == PAUSE)) begin
      dir_down_d = mode;
      ps_d       = '0;
      if (start_at_term) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (ps_q == PS_MAX) begin
        ps_d     = '0;
        digits_d = step_val;
        if (step_val == term_val) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ps_q       <= '0;
      dir_down_q <= 1'b0;
      digits_q   <= 16'h0000;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      dir_down_q <= dir_down_d;
      digits_q   <= digits_d;
      running_q  <= running_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign digits   = digits_q;
  assign running  = running_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

module FourBitCarryLookAheadAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum
);

  logic [3:0] g, p, c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c;

endmodule

// File: tb/tb_two_mode_timer_counter.sv
// Bench for two_mode_timer_counter: seconds-based reference model feeds a scoreboard queue,
// a monitor compares every cycle; directed scenarios add constant checks.
module tb_two_mode_timer_counter;

  localparam int CLK_DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  localparam int MAX_SECS = 99 * 60 + 59;

  logic        clk = 1'b0;
  logic        rst = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] digits;
  logic        running, done, load_err;

  two_mode_timer_counter #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .digits(digits), .running(running), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        load_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: time kept as plain seconds.
  int m_state = S_IDLE;
  int m_secs = 0;
  int m_ps = 0;
  bit m_down = 1'b0;
  bit m_done, m_lerr;

  function automatic logic [15:0] to_bcd(input int s);
    int mins, secs;
    mins = s / 60;
    secs = s % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
  endfunction

  function automatic bit is_legal(input logic [15:0] v);
    return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 5) && (v[3:0] <= 9);
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, l, input logic [15:0] lv, input bit sa, so, md);
    m_done = 1'b0;
    m_lerr = 1'b0;
    if (r) begin
      m_state = S_IDLE; m_secs = 0; m_ps = 0; m_down = 1'b0;
    end else if (l) begin
      if (is_legal(lv)) begin
        m_secs = from_bcd(lv); m_ps = 0; m_state = S_IDLE;
      end else m_lerr = 1'b1;
    end else if (so) begin
      if (m_state == S_RUN) m_state = S_PAUSE;
    end else if (sa && (m_state == S_IDLE || m_state == S_PAUSE)) begin
      m_down = md;
      m_ps = 0;
      if (m_secs == (m_down ? 0 : MAX_SECS)) begin
        m_state = S_DONE; m_done = 1'b1;
      end else m_state = S_RUN;
    end else if (m_state == S_RUN) begin
      if (m_ps == CLK_DIV - 1) begin
        m_ps = 0;
        m_secs = m_down ? m_secs - 1 : m_secs + 1;
        if (m_secs == (m_down ? 0 : MAX_SECS)) begin
          m_state = S_DONE; m_done = 1'b1;
        end
      end else m_ps++;
    end
  endtask

  // Drive one cycle from the negedge, queue the model's post-edge outputs, return at next negedge.
  task automatic tick(input bit r, l, input logic [15:0] lv, input bit sa, so, md);
    exp_t e;
    rst = r; load = l; load_val = lv; start = sa; stop = so; mode = md;
    model_step(r, l, lv, sa, so, md);
    e.digits = to_bcd(m_secs);
    e.running = (m_state == S_RUN);
    e.done = m_done;
    e.load_err = m_lerr;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 16'h0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_digits", digits, e.digits);
      check("sb_running", {15'd0, running}, {15'd0, e.running});
      check("sb_done", {15'd0, done}, {15'd0, e.done});
      check("sb_load_err", {15'd0, load_err}, {15'd0, e.load_err});
    end
  end

  initial begin
    logic [15:0] lv;
    int s;
    @(negedge clk);

    tick(1, 0, 16'h0, 0, 0, 0);
    check("reset_digits", digits, 16'h0000);
    check("reset_flags", {13'd0, running, done, load_err}, 16'h0);

    // Up count across minute boundary
    tick(0, 1, 16'h0058, 0, 0, 0);
    check("load_0058", digits, 16'h0058);
    tick(0, 0, 16'h0, 1, 0, 0);
    check("run_up", {15'd0, running}, 16'h1);
    idle(3);
    check("no_early_step", digits, 16'h0058);
    idle(1);
    check("up_0059", digits, 16'h0059);
    idle(4);
    check("up_0100", digits, 16'h0100);
    check("still_running", {15'd0, running}, 16'h1);

    // Down count to zero
    tick(0, 1, 16'h0002, 0, 0, 0);
    tick(0, 0, 16'h0, 1, 0, 1);
    idle(4);
    check("down_0001", digits, 16'h0001);
    idle(4);
    check("down_0000", digits, 16'h0000);
    check("down_done", {14'd0, running, done}, 16'h1);
    idle(1);
    check("done_one_cycle", {15'd0, done}, 16'h0);
    tick(0, 0, 16'h0, 1, 0, 1);
    check("done_ignores_start", {14'd0, running, done}, 16'h0);

    // Up terminal 99:59
    tick(0, 1, 16'h9958, 0, 0, 0);
    tick(0, 0, 16'h0, 1, 0, 0);
    idle(4);
    check("up_9959", digits, 16'h9959);
    check("up_done", {14'd0, running, done}, 16'h1);
    tick(0, 0, 16'h0, 1, 0, 0);
    check("done_hold", digits, 16'h9959);

    // Borrow chain
    tick(0, 1, 16'h1000, 0, 0, 0);
    tick(0, 0, 16'h0, 1, 0, 1);
    idle(4);
    check("borrow_0959", digits, 16'h0959);
    idle(4);
    check("borrow_0958", digits, 16'h0958);

    // Illegal loads while paused
    tick(0, 0, 16'h0, 0, 1, 0);
    tick(0, 1, 16'h0070, 0, 0, 0);
    check("lerr_0070", {15'd0, load_err}, 16'h1);
    check("lerr_0070_digits", digits, 16'h0958);
    idle(1);
    check("lerr_pulse", {15'd0, load_err}, 16'h0);
    tick(0, 1, 16'h00A0, 0, 0, 0);
    check("lerr_00A0", {15'd0, load_err}, 16'h1);
    check("lerr_00A0_digits", digits, 16'h0958);

    // Start at terminal goes straight to DONE
    tick(0, 1, 16'h0000, 0, 0, 0);
    tick(0, 0, 16'h0, 1, 0, 1);
    check("start_at_zero", {14'd0, running, done}, 16'h1);

    // Pause / resume
    tick(0, 1, 16'h0010, 0, 0, 0);
    tick(0, 0, 16'h0, 1, 0, 0);
    idle(2);
    for (int k = 0; k < 10; k++) tick(0, 0, 16'h0, 0, 1, 0);
    check("pause_hold", {digits[14:0], running}, {15'h0010, 1'b0});
    tick(0, 0, 16'h0, 1, 0, 0);
    idle(3);
    check("resume_no_step", digits, 16'h0010);
    idle(1);
    check("resume_step", digits, 16'h0011);
    tick(0, 0, 16'h0, 1, 1, 0);
    check("stop_beats_start", {15'd0, running}, 16'h0);
    tick(0, 0, 16'h0, 1, 0, 0);
    idle(2);

    // rst beats load mid-run
    tick(1, 1, 16'h1234, 0, 0, 0);
    check("rst_over_load", digits, 16'h0000);
    check("rst_flags", {13'd0, running, done, load_err}, 16'h0);
    idle(1);
    check("rst_idle", {15'd0, running}, 16'h0);

    // Randomized stimulus
    for (int n = 0; n < 3000; n++) begin
      bit r, l, sa, so, md;
      r  = ($urandom_range(0, 199) == 0);
      l  = ($urandom_range(0, 19) == 0);
      so = ($urandom_range(0, 14) == 0);
      sa = ($urandom_range(0, 5) == 0);
      md = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: s = $urandom_range(0, 3);
        1: s = MAX_SECS - int'($urandom_range(0, 3));
        default: s = $urandom_range(0, MAX_SECS);
      endcase
      lv = to_bcd(s);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: lv[3:0]   = 4'($urandom_range(10, 15));
          1: lv[7:4]   = 4'($urandom_range(6, 15));
          2: lv[11:8]  = 4'($urandom_range(10, 15));
          default: lv[15:12] = 4'($urandom_range(10, 15));
        endcase
      end
      tick(r, l, lv, sa, so, md);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
